// File: rtl/reg_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_load_ctrl                                                |
// | Description : Debounced load button -> one-cycle write pulse + 4-bit data  |
// |               for a downstream register. Define REG_LOAD_CTRL_REPEAT_EN to |
// |               enable auto-repeat while the button is held.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_load_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_load,
    input  logic [3:0] sw,
    output logic       we,
    output logic [3:0] datain,
    output logic [7:0] load_count
);

    localparam int C_DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DB_PRESS   = 2'd1,
        S_PRESSED    = 2'd2,
        S_DB_RELEASE = 2'd3
    } state_t;

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("reg_load_ctrl: parameter out of range");
        end
    endgenerate

    // Index 0 is the newest sample; bit 4 carries the button, bits 3:0 the switches.
    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic                        w_btn_s;
    logic [3:0]                  w_sw_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {btn_load, sw}};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1][4];
    assign w_sw_s  = r_sync[SYNC_STAGES-1][3:0];

    state_t            r_state;
    state_t            w_state_next;
    logic [C_DB_W-1:0] r_db_cnt;
    logic [C_DB_W-1:0] w_db_cnt_next;
    logic              w_load;
    logic              w_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_db_cnt <= w_db_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_db_cnt_next = r_db_cnt;
        w_load        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_btn_s) begin
                    w_state_next  = S_DB_PRESS;
                    w_db_cnt_next = '0;
                end
            end
            S_DB_PRESS: begin
                if (!w_btn_s) begin
                    w_state_next = S_IDLE;
                end else if (r_db_cnt == C_DB_LAST) begin
                    w_state_next = S_PRESSED;
                    w_load       = 1'b1;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!w_btn_s) begin
                    w_state_next  = S_DB_RELEASE;
                    w_db_cnt_next = '0;
                end
            end
            S_DB_RELEASE: begin
                // A bounce back high returns to PRESSED without a new pulse.
                if (w_btn_s) begin
                    w_state_next = S_PRESSED;
                end else if (r_db_cnt == C_DB_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_db_cnt_next = '0;
            end
        endcase
    end

`ifdef REG_LOAD_CTRL_REPEAT_EN
    localparam int C_RP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [C_RP_W-1:0] C_RP_LAST = C_RP_W'(REPEAT_CYCLES - 1);

    logic [C_RP_W-1:0] r_rep_cnt;
    logic              w_rep_hold;
    logic              w_rep_fire;
    logic              w_enter_pressed;

    assign w_enter_pressed = (w_state_next == S_PRESSED) && (r_state != S_PRESSED);
    assign w_rep_hold      = (r_state == S_PRESSED) && w_btn_s;
    assign w_rep_fire      = w_rep_hold && (r_rep_cnt == C_RP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (w_enter_pressed) begin
            r_rep_cnt <= '0;
        end else if (w_rep_hold) begin
            r_rep_cnt <= w_rep_fire ? '0 : r_rep_cnt + 1'b1;
        end
    end

    assign w_pulse = w_load | w_rep_fire;
`else
    assign w_pulse = w_load;
`endif

    logic       r_we;
    logic [3:0] r_datain;
    logic [7:0] r_load_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_datain     <= 4'h0;
            r_load_count <= 8'h00;
        end else begin
            r_we <= w_pulse;
            if (w_pulse) begin
                r_datain     <= w_sw_s;
                r_load_count <= r_load_count + 8'd1;
            end
        end
    end

    assign we         = r_we;
    assign datain     = r_datain;
    assign load_count = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_load_ctrl                                             |
// | Description : Self-checking bench for reg_load_ctrl (vector table, corner  |
// |               sequences, random stimulus against a reference model).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reg_load_ctrl;

    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RP = 8;
`ifdef REG_LOAD_CTRL_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_load = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       we;
    logic [3:0] datain;
    logic [7:0] load_count;

    reg_load_ctrl #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_load   (btn_load),
        .sw         (sw),
        .we         (we),
        .datain     (datain),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int obs_pulses = 0;

    // Reference model: a button level is accepted once the synchronized input has
    // disagreed with the current level for DB+1 consecutive edges.
    logic [4:0] m_pipe[$];
    logic       m_level;
    int         m_run;
    int         m_held;
    logic       m_we;
    logic [3:0] m_data;
    logic [7:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SS; i++) m_pipe.push_back(5'h00);
        m_level = 1'b0;
        m_run   = 0;
        m_held  = 0;
        m_we    = 1'b0;
        m_data  = 4'h0;
        m_count = 8'h00;
    endtask

    task automatic model_pulse(input logic [3:0] d);
        m_we    = 1'b1;
        m_data  = d;
        m_count = m_count + 8'd1;
    endtask

    task automatic model_edge();
        logic [4:0] s;
        s = m_pipe[$];
        void'(m_pipe.pop_back());
        m_pipe.push_front({btn_load, sw});
        m_we = 1'b0;
        if (s[4] != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = s[4];
                m_run   = 0;
                m_held  = 0;
                if (m_level) model_pulse(s[3:0]);
            end
        end else begin
            if (m_level && m_run == 0) begin
                m_held++;
                if (REP_ON == 1 && m_held == RP) begin
                    m_held = 0;
                    model_pulse(s[3:0]);
                end
            end else if (m_level) begin
                m_held = 0;
            end
            m_run = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check("cyc_we", {31'd0, we}, {31'd0, m_we});
        check("cyc_datain", {28'd0, datain}, {28'd0, m_data});
        check("cyc_load_count", {24'd0, load_count}, {24'd0, m_count});
        if (we) obs_pulses++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_datain", {28'd0, datain}, 32'd0);
        check("rst_load_count", {24'd0, load_count}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input int hold, input int low, output int pulses);
        int p0;
        p0 = obs_pulses;
        btn_load = 1'b1;
        repeat (hold) step();
        btn_load = 1'b0;
        repeat (low) step();
        pulses = obs_pulses - p0;
    endtask

    typedef struct {
        int         hold;
        logic [3:0] swv;
        int         p_base;
        int         p_rep;
        logic [3:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p;
        int   first;
        int   exp_cnt;
        logic [3:0] cap_d;
        logic [7:0] cap_c;

        vecs[0] = '{1,  4'h3, 0, 0, 4'h0};
        vecs[1] = '{2,  4'h7, 0, 0, 4'h0};
        vecs[2] = '{4,  4'h9, 0, 0, 4'h0};
        vecs[3] = '{5,  4'hC, 1, 0, 4'hC};
        vecs[4] = '{20, 4'h6, 1, 1, 4'h6};
        vecs[5] = '{3,  4'hF, 0, 0, 4'h6};
        vecs[6] = '{13, 4'h1, 1, 1, 4'h1};

        model_reset();
        @(negedge clk);
        do_reset();

        // Vector table: press length vs. accepted pulses.
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            sw = vecs[i].swv;
            press(vecs[i].hold, 12, p);
            exp_cnt += vecs[i].p_base + REP_ON * vecs[i].p_rep;
            check($sformatf("vec%0d_pulses", i), p, vecs[i].p_base + REP_ON * vecs[i].p_rep);
            check($sformatf("vec%0d_datain", i), {28'd0, datain}, {28'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_count", i), {24'd0, load_count}, exp_cnt);
        end

        // Latency of a clean press: pulse in the cycle after edge 7.
        do_reset();
        sw = 4'hA;
        btn_load = 1'b1;
        first = 0;
        cap_d = 4'h0;
        cap_c = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (we && first == 0) begin
                first = i;
                cap_d = datain;
                cap_c = load_count;
            end
        end
        btn_load = 1'b0;
        repeat (12) step();
        check("lat_first_pulse", first, 7);
        check("lat_datain", {28'd0, cap_d}, 32'hA);
        check("lat_count", {24'd0, cap_c}, 32'd1);

        // Release bounce must not produce an extra pulse.
        do_reset();
        sw = 4'h3;
        press(10, 0, p);
        check("bounce_first_pulse", p, 1);
        p = obs_pulses;
        btn_load = 1'b0; step();
        btn_load = 1'b1; step();
        btn_load = 1'b0; step();
        btn_load = 1'b1; step();
        btn_load = 1'b0;
        repeat (12) step();
        check("bounce_no_pulse", obs_pulses - p, 0);
        sw = 4'h5;
        press(8, 12, p);
        check("bounce_second_datain", {28'd0, datain}, 32'h5);
        check("bounce_second_count", {24'd0, load_count}, 32'd2);

        // Reset in the middle of a debounce with the button still held afterwards.
        do_reset();
        sw = 4'h9;
        press(8, 12, p);
        check("rstmid_pre_count", {24'd0, load_count}, 32'd1);
        sw = 4'h3;
        btn_load = 1'b1;
        repeat (4) step();
        do_reset();
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            step();
            if (we) first = i;
        end
        check("rstmid_first_pulse", first, 7);
        check("rstmid_datain", {28'd0, datain}, 32'h3);
        check("rstmid_count", {24'd0, load_count}, 32'd1);
        btn_load = 1'b0;
        repeat (12) step();

        // Long hold with switches stepped after every pulse.
        do_reset();
        sw = 4'h0;
        btn_load = 1'b1;
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            step();
            if (we) begin
                first = i;
                sw = sw + 4'h1;
            end
        end
        check("hold_first_pulse", first, 7);
        p = obs_pulses;
        repeat (40) begin
            step();
            if (we) sw = sw + 4'h1;
        end
        check("hold_repeat_pulses", obs_pulses - p, 5 * REP_ON);
        check("hold_datain", {28'd0, datain}, 5 * REP_ON);
        btn_load = 1'b0;
        repeat (12) step();

        // 256 loads wrap the counter.
        do_reset();
        p = obs_pulses;
        for (int i = 0; i < 256; i++) begin
            int q;
            sw = 4'(i);
            press(6, 8, q);
            if (i == 254) check("wrap_count_255", {24'd0, load_count}, 32'd255);
        end
        check("wrap_pulses", obs_pulses - p, 256);
        check("wrap_count_0", {24'd0, load_count}, 32'd0);

        // Random button activity and switch noise against the model.
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            btn_load = 1'($urandom_range(0, 1));
            sw = 4'($urandom);
            len = $urandom_range(1, 12);
            repeat (len) begin
                if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
                step();
            end
        end
        btn_load = 1'b0;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
